// File: rtl/demux_stream_router_if.sv
// ---------------------------------------------------------------------------
// demux_stream_router_if
// Bundles the single producer-side stream and the NCH consumer-side streams
// of the demultiplexing router.
//   in_data/in_sel/in_valid/auto_mode : producer -> router
//   in_ready                          : router -> producer (combinational)
//   out_data/out_valid                : router -> consumers (registered)
//   out_ready                         : consumers -> router
//   rr_ptr                            : router status, round-robin pointer
// Modports: slave = router side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface demux_stream_router_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
);
  localparam int NCH = 2 ** SEL_W;

  logic [WIDTH-1:0]     in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic                 auto_mode;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [SEL_W-1:0]     rr_ptr;

  modport slave (
    input  in_data, in_sel, in_valid, auto_mode, out_ready,
    output in_ready, out_data, out_valid, rr_ptr
  );

  modport master (
    output in_data, in_sel, in_valid, auto_mode, out_ready,
    input  in_ready, out_data, out_valid, rr_ptr
  );
endinterface

// File: rtl/demux_stream_router.sv
// ---------------------------------------------------------------------------
// demux_stream_router
// Registered 1-to-NCH stream demultiplexer. Each accepted word goes to one
// channel, chosen by in_sel or by an internal round-robin pointer. Every
// channel owns a single-entry holding register, so a stalled consumer only
// blocks input words aimed at its own channel.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : demux_stream_router_if.slave (stream in, NCH streams out, rr_ptr)
// ---------------------------------------------------------------------------
module demux_stream_router #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_stream_router_if.slave  bus
);
  localparam int NCH = 2 ** SEL_W;

  logic [NCH-1:0][WIDTH-1:0] data_q, data_d;
  logic [NCH-1:0]            valid_q, valid_d;
  logic [SEL_W-1:0]          rr_q, rr_d;

  logic [SEL_W-1:0]          tgt_s;
  logic                      in_ready_s;
  logic                      accept_s;

  // Target selection and input handshake; a full slot being popped this
  // edge can take the new word at the same time (pass-through refill).
  always_comb begin
    tgt_s      = {SEL_W{1'b0}};
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    if (bus.auto_mode) begin
      tgt_s = rr_q;
    end else begin
      tgt_s = bus.in_sel;
    end
    in_ready_s = ~valid_q[tgt_s] | bus.out_ready[tgt_s];
    accept_s   = bus.in_valid & in_ready_s;
  end

  // Next state of the holding registers and the round-robin pointer.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~bus.out_ready;  // pops clear their slot
    rr_d    = rr_q;
    if (accept_s) begin
      // An accept on a popping slot overrides the clear above.
      data_d[tgt_s]  = bus.in_data;
      valid_d[tgt_s] = 1'b1;
      if (bus.auto_mode) begin
        rr_d = rr_q + SEL_W'(1);  // wraps naturally at NCH-1
      end else begin
        rr_d = rr_q;
      end
    end else begin
      data_d[tgt_s]  = data_q[tgt_s];
      valid_d[tgt_s] = valid_q[tgt_s] & ~bus.out_ready[tgt_s];
    end
  end

  // State registers with asynchronous reset discarding pending words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= {NCH{1'b0}};
      rr_q    <= {SEL_W{1'b0}};
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.rr_ptr    = rr_q;
endmodule
